// File: rtl/alu_arb_ctrl.sv
// Round-robin front end sharing one fixed-latency ALU between two requesters.
// One command in flight; the response is held until its owner consumes it.

module alu_arb_lane (
  input  logic idle,
  input  logic resp,
  input  logic win,
  input  logic own,
  input  logic req_valid,
  input  logic rsp_ready,
  output logic req_ready,
  output logic rsp_valid,
  output logic rsp_hs
);
  assign req_ready = idle & win & req_valid;
  assign rsp_valid = resp & own;
  assign rsp_hs    = rsp_valid & rsp_ready;
endmodule

module alu_arb_ctrl #(
  parameter int ALU_LAT = 1,
  parameter int W       = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [3:0]   req0_sel,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [3:0]   req1_sel,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_ovf,
  output logic         rsp_err,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [W-1:0] alu_out,
  input  logic         alu_ovf,
  output logic         busy
);
  localparam int         NREQ     = 2;
  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   sel;
  } cmd_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q;
  logic last_q, own_q;
  logic [NREQ-1:0] req_v, req_r, rsp_v, rsp_r, rsp_hs;
  cmd_t [NREQ-1:0] req_cmd;
  cmd_t acc_cmd;
  logic gnt_idx, idle, resp, acc, legal, arith;

  assign req_v      = {req1_valid, req0_valid};
  assign rsp_r      = {rsp1_ready, rsp0_ready};
  assign req_cmd[0] = {req0_a, req0_b, req0_sel};
  assign req_cmd[1] = {req1_a, req1_b, req1_sel};

  // Lone requester wins; on a tie the one that did not win last time.
  assign gnt_idx = (&req_v) ? ~last_q : req_v[1];
  assign idle    = (state_q == IDLE);
  assign resp    = (state_q == RESP);
  assign acc     = idle & (|req_v);
  assign acc_cmd = req_cmd[gnt_idx];
  assign legal   = (acc_cmd.sel <= 4'd4);
  // Only ADD/SUB report overflow; anything the ALU says for logic ops is dropped.
  assign arith   = (alu_sel == 4'd3) || (alu_sel == 4'd4);

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    alu_arb_lane u_lane (
      .idle      (idle),
      .resp      (resp),
      .win       (gnt_idx == 1'(g)),
      .own       (own_q == 1'(g)),
      .req_valid (req_v[g]),
      .rsp_ready (rsp_r[g]),
      .req_ready (req_r[g]),
      .rsp_valid (rsp_v[g]),
      .rsp_hs    (rsp_hs[g])
    );
  end

  assign req0_ready = req_r[0];
  assign req1_ready = req_r[1];
  assign rsp0_valid = rsp_v[0];
  assign rsp1_valid = rsp_v[1];
  assign busy       = ~idle;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc) state_d = legal ? EXEC : RESP;
      EXEC:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (|rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      own_q    <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      rsp_data <= '0;
      rsp_ovf  <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        own_q  <= gnt_idx;
        last_q <= gnt_idx;
        // Illegal opcodes never reach the ALU, so its inputs stay put.
        if (legal) begin
          alu_a   <= acc_cmd.a;
          alu_b   <= acc_cmd.b;
          alu_sel <= acc_cmd.sel;
          cnt_q   <= CNT_INIT;
        end else begin
          rsp_data <= '0;
          rsp_ovf  <= 1'b0;
          rsp_err  <= 1'b1;
        end
      end
      if (state_q == EXEC) begin
        if (cnt_q == '0) begin
          rsp_data <= alu_out;
          rsp_ovf  <= alu_ovf & arith;
          rsp_err  <= 1'b0;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Directed + random bench for alu_arb_ctrl with a modelled external ALU and
// an arithmetic reference for the expected responses.

module tb_alu_arb_ctrl;
  localparam longint LIM = 64'sd2147483647;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0]  rv, rdy, rsv, rsr;
  logic [31:0] ra [2];
  logic [31:0] rb [2];
  logic [3:0]  rs [2];
  logic [31:0] rsp_data, alu_a, alu_b, alu_out;
  logic        rsp_ovf, rsp_err, alu_ovf, busy;
  logic [3:0]  alu_sel;

  logic [1:0]  q_rv, q_rdy, q_rsv, q_rsr;
  logic [31:0] q_ra [2];
  logic [31:0] q_rb [2];
  logic [3:0]  q_rs [2];
  logic [31:0] q_data, q_aa, q_ab, q_ao;
  logic        q_ovf, q_err, q_aovf, q_busy;
  logic [3:0]  q_as;

  alu_arb_ctrl #(.ALU_LAT(1), .W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rv[0]), .req0_ready(rdy[0]), .req0_a(ra[0]), .req0_b(rb[0]), .req0_sel(rs[0]),
    .rsp0_valid(rsv[0]), .rsp0_ready(rsr[0]),
    .req1_valid(rv[1]), .req1_ready(rdy[1]), .req1_a(ra[1]), .req1_b(rb[1]), .req1_sel(rs[1]),
    .rsp1_valid(rsv[1]), .rsp1_ready(rsr[1]),
    .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_ovf(alu_ovf),
    .busy(busy)
  );

  alu_arb_ctrl #(.ALU_LAT(4), .W(32)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(q_rv[0]), .req0_ready(q_rdy[0]), .req0_a(q_ra[0]), .req0_b(q_rb[0]), .req0_sel(q_rs[0]),
    .rsp0_valid(q_rsv[0]), .rsp0_ready(q_rsr[0]),
    .req1_valid(q_rv[1]), .req1_ready(q_rdy[1]), .req1_a(q_ra[1]), .req1_b(q_rb[1]), .req1_sel(q_rs[1]),
    .rsp1_valid(q_rsv[1]), .rsp1_ready(q_rsr[1]),
    .rsp_data(q_data), .rsp_ovf(q_ovf), .rsp_err(q_err),
    .alu_a(q_aa), .alu_b(q_ab), .alu_sel(q_as), .alu_out(q_ao), .alu_ovf(q_aovf),
    .busy(q_busy)
  );

  // Environment ALU: reports ovf=1 for logic ops and junk for bad opcodes,
  // so the controller's masking is actually exercised.
  function automatic logic [32:0] env_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] s);
    logic [31:0] r;
    logic o;
    case (s)
      4'd0: begin r = a & b; o = 1'b1; end
      4'd1: begin r = a | b; o = 1'b1; end
      4'd2: begin r = a ^ b; o = 1'b1; end
      4'd3: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd4: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
      default: begin r = 32'hDEAD_BEEF; o = 1'b1; end
    endcase
    return {o, r};
  endfunction

  logic [32:0] p1 = '0;
  logic [32:0] qp [4] = '{default: '0};
  always @(posedge clk) begin
    p1 <= env_alu(alu_a, alu_b, alu_sel);
    qp[0] <= env_alu(q_aa, q_ab, q_as);
    for (int i = 1; i < 4; i++) qp[i] <= qp[i-1];
  end
  assign {alu_ovf, alu_out} = p1;
  assign {q_aovf, q_ao} = qp[3];

  // Reference: {err, ovf, data} from signed 64-bit arithmetic.
  function automatic logic [33:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] s);
    longint sa, sb, r;
    logic [33:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 0;
    res = '0;
    case (s)
      4'd0: res[31:0] = a & b;
      4'd1: res[31:0] = a | b;
      4'd2: res[31:0] = a ^ b;
      4'd3, 4'd4: begin
        r = (s == 4'd3) ? sa + sb : sa - sb;
        res[31:0] = r[31:0];
        res[32] = (r > LIM) || (r < -LIM - 1);
      end
      default: res[33] = 1'b1;
    endcase
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(output int who);
    bit found = 1'b0;
    who = -1;
    for (int i = 0; i < 50 && !found; i++) begin
      #1;
      if (rdy != 2'b00) begin
        found = 1'b1;
        who = rdy[1] ? 1 : 0;
        chk("ready_onehot", 64'(rdy == 2'b11), 64'd0);
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("grant_seen", 64'(found), 64'd1);
  endtask

  task automatic finish_rsp(input int r, input logic [33:0] exp, input int hold);
    int n = 0;
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #2;
      n++;
      chk("other_rsp_low", 64'(rsv[1-r]), 64'd0);
      if (rsv[r]) got = 1'b1;
    end
    chk("rsp_seen", 64'(got), 64'd1);
    chk("rsp_latency", 64'(n), exp[33] ? 64'd1 : 64'd2);
    chk("rsp_data", 64'(rsp_data), 64'(exp[31:0]));
    chk("rsp_ovf", 64'(rsp_ovf), 64'(exp[32]));
    chk("rsp_err", 64'(rsp_err), 64'(exp[33]));
    for (int i = 0; i < hold; i++) begin
      rsr[1-r] = 1'b1;
      @(posedge clk); #2;
      chk("hold_valid", 64'(rsv[r]), 64'd1);
      chk("hold_data", 64'({rsp_err, rsp_ovf, rsp_data}), 64'(exp));
      chk("hold_other_ready", 64'(rdy[1-r]), 64'd0);
    end
    rsr[1-r] = 1'b0;
    rsr[r] = 1'b1;
    @(posedge clk); #2;
    chk("rsp_dropped", 64'(rsv), 64'd0);
    chk("idle_after_rsp", 64'(busy), 64'd0);
    rsr = 2'b00;
  endtask

  task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] s, input int hold, input bit bp);
    int who;
    logic [33:0] e;
    ra[r] = a; rb[r] = b; rs[r] = s; rv[r] = 1'b1;
    wait_grant(who);
    chk("grant_owner", 64'(who), 64'(r));
    e = ref_model(a, b, s);
    @(posedge clk); #1;
    rv[r] = 1'b0;
    if (bp) begin
      ra[1-r] = 32'd7; rb[1-r] = 32'd9; rs[1-r] = 4'd1; rv[1-r] = 1'b1;
    end
    finish_rsp(r, e, hold);
  endtask

  function automatic logic [3:0] rnd_legal();
    return 4'($urandom_range(0, 4));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int who, n;
    bit got;
    logic [3:0] s_before;
    logic [3:0] s;
    logic [33:0] e;

    rv = '0; rsr = '0; q_rv = '0; q_rsr = '0;
    for (int i = 0; i < 2; i++) begin
      ra[i] = '0; rb[i] = '0; rs[i] = '0;
      q_ra[i] = '0; q_rb[i] = '0; q_rs[i] = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("reset_ctrl", 64'({rdy, rsv, rsp_ovf, rsp_err, busy, alu_sel}), 64'd0);
    chk("reset_data", 64'(rsp_data), 64'd0);
    chk("reset_alu_ab", {alu_a, alu_b}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single ADD, then overflow cases on requester 1
    run_op(0, 32'd5, 32'd3, 4'd3, 0, 1'b0);
    chk("single_add_value", 64'(rsp_data), 64'd8);
    run_op(1, 32'h7FFF_FFFF, 32'd1, 4'd3, 0, 1'b0);
    run_op(1, 32'h8000_0000, 32'd1, 4'd4, 0, 1'b0);
    run_op(0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd0, 0, 1'b0);

    // Backpressure: requester 1 waits behind a held response
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 10, 1'b1);
    run_op(1, 32'd7, 32'd9, 4'd1, 0, 1'b0);

    // Illegal opcode leaves the ALU inputs alone
    s_before = alu_sel;
    run_op(0, 32'h1234_5678, 32'h9ABC_DEF0, 4'hA, 0, 1'b0);
    chk("illegal_alu_sel", 64'(alu_sel), 64'(s_before));

    // Reset in the middle of EXEC
    ra[0] = 32'd100; rb[0] = 32'd1; rs[0] = 4'd4; rv[0] = 1'b1;
    wait_grant(who);
    @(posedge clk); #1;
    rv[0] = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_ctrl", 64'({rdy, rsv, rsp_ovf, rsp_err, busy, alu_sel}), 64'd0);
    chk("midreset_data", 64'(rsp_data), 64'd0);
    chk("midreset_alu_ab", {alu_a, alu_b}, 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      chk("no_stale_rsp", 64'({rsv, busy}), 64'd0);
    end
    run_op(1, 32'd40, 32'd2, 4'd4, 0, 1'b0);

    // Round-robin with both requesters valid from reset
    rst_n = 1'b0;
    @(posedge clk); #2;
    for (int i = 0; i < 2; i++) begin
      ra[i] = $urandom; rb[i] = $urandom; rs[i] = rnd_legal();
    end
    rv = 2'b11;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_grant(who);
      if (who < 0) break;
      chk("rr_order", 64'(who), 64'(k % 2));
      e = ref_model(ra[who], rb[who], rs[who]);
      @(posedge clk); #1;
      if (k >= 6) rv[who] = 1'b0;
      else begin
        ra[who] = $urandom; rb[who] = $urandom; rs[who] = rnd_legal();
      end
      finish_rsp(who, e, 0);
    end
    rv = 2'b00;

    // Random traffic
    for (int k = 0; k < 24; k++) begin
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(5, 15)) : rnd_legal();
      run_op(int'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : 32'($urandom),
             ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'($urandom),
             s, int'($urandom_range(0, 2)), 1'b0);
    end

    // ALU_LAT=4 instance: response 5 cycles after accept
    q_ra[0] = 32'd5; q_rb[0] = 32'd3; q_rs[0] = 4'd3; q_rv[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (q_rdy[0]) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("lat4_grant", 64'(got), 64'd1);
    @(posedge clk); #1;
    q_rv[0] = 1'b0;
    n = 0; got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge clk); #2;
      n++;
      if (q_rsv[0]) got = 1'b1;
    end
    chk("lat4_latency", 64'(n), 64'd5);
    chk("lat4_rsp", 64'({q_err, q_ovf, q_data}), 64'(ref_model(32'd5, 32'd3, 4'd3)));
    q_rsr[0] = 1'b1;
    @(posedge clk); #2;
    chk("lat4_dropped", 64'({q_rsv, q_busy}), 64'd0);
    q_rsr[0] = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
